// File: rtl/hcvc_conv_pkg.sv
// Shared definitions for the HCVC-HEM convolution blocks (conv1x1 / deconv1x1).
//
// Contents:
//   state_t     - sequencer state encoding (IDLE, FILL, MAC, WRITE, DONE)
//   tensor_idx  - flat element index of an NCHW tensor: ((b*C+c)*H+h)*W+w
//   acc_width   - accumulator width for a dot product of n signed dw-bit pairs
//   cnt_width   - width of a loop counter that counts 0..n-1 (at least 1 bit)
package hcvc_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic int tensor_idx(input int b, input int c, input int h, input int w,
                                    input int num_c, input int num_h, input int num_w);
    return ((b * num_c + c) * num_h + h) * num_w + w;
  endfunction

  // Full 2*dw product plus enough headroom to sum n of them without overflow.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/deconv_mac.sv
// Signed multiply-accumulate datapath for deconv1x1.
//
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   clear      restart the sum with this cycle's product (first input channel)
//   en         accumulate x*w this cycle
//   x, w       signed operands
//   bias       signed bias added to the accumulated sum
//   result     low DATA_WIDTH bits of (acc + bias); clamped at zero when
//              DECONV1X1_RELU_EN is defined
module deconv_mac
  import hcvc_conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IN_CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, IN_CHANNELS);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0]     product;
  logic signed [ACC_W-1:0]      acc;
  logic        [DATA_WIDTH-1:0] sum_low;

  // Sign-extending casts keep the full signed product.
  assign product = PROD_W'(x) * PROD_W'(w);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= (clear ? '0 : acc) + ACC_W'(product);
    end
  end

  // Only the low bits are stored, and they do not depend on the upper
  // accumulator bits, so the wrapping add is done at the output width.
  assign sum_low = DATA_WIDTH'(acc) + bias;

`ifdef DECONV1X1_RELU_EN
  assign result = sum_low[DATA_WIDTH-1] ? '0 : sum_low;
`else
  assign result = sum_low;
`endif

endmodule

// File: rtl/deconv1x1.sv
// Transposed 1x1 convolution (upsampling by STRIDE), decoder-side partner of
// conv1x1. One MAC per cycle behind a start/busy/done handshake.
//
//   out[b][oc][h*S][w*S] = bias[oc] + sum_ic W[ic][oc] * x[b][ic][h][w]
//   every other output position = bias[oc]
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   start               1-cycle request, sampled only in IDLE
//   input_tensor_flat   x, element ((b*IC+ic)*IH+h)*IW+w at [i*DW +: DW]
//   weights_flat        W[ic][oc] at index ic*OC+oc
//   bias_flat           bias[oc] at index oc
//   busy                high in FILL/MAC/WRITE
//   done                1-cycle pulse when output_tensor_flat is complete
//   output_tensor_flat  ((b*OC+oc)*OH+y)*OW+x; held until the next start
//
// Build option: define DECONV1X1_RELU_EN to clamp every stored value
// (bias fill and computed results) at zero. Timing is identical.
module deconv1x1
  import hcvc_conv_pkg::*;
#(
  parameter int BATCH_SIZE   = 1,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int IN_HEIGHT    = 4,
  parameter int IN_WIDTH     = 4,
  parameter int STRIDE       = 2,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                                                                     clk,
  input  logic                                                                     rst,
  input  logic                                                                     start,
  input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]          input_tensor_flat,
  input  logic [IN_CHANNELS*OUT_CHANNELS*DATA_WIDTH-1:0]                           weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                                       bias_flat,
  output logic                                                                     busy,
  output logic                                                                     done,
  output logic [BATCH_SIZE*OUT_CHANNELS*IN_HEIGHT*STRIDE*IN_WIDTH*STRIDE*DATA_WIDTH-1:0] output_tensor_flat
);

  localparam int OUT_HEIGHT = IN_HEIGHT * STRIDE;
  localparam int OUT_WIDTH  = IN_WIDTH * STRIDE;
  localparam int OUT_ELEMS  = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH;
  localparam int PLANE      = OUT_HEIGHT * OUT_WIDTH;

  localparam int B_W  = cnt_width(BATCH_SIZE);
  localparam int IC_W = cnt_width(IN_CHANNELS);
  localparam int OC_W = cnt_width(OUT_CHANNELS);
  localparam int H_W  = cnt_width(IN_HEIGHT);
  localparam int W_W  = cnt_width(IN_WIDTH);

  localparam logic [B_W-1:0]  B_LAST  = B_W'(BATCH_SIZE - 1);
  localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_CHANNELS - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OUT_CHANNELS - 1);
  localparam logic [H_W-1:0]  H_LAST  = H_W'(IN_HEIGHT - 1);
  localparam logic [W_W-1:0]  W_LAST  = W_W'(IN_WIDTH - 1);

  state_t state, state_next;

  logic [B_W-1:0]  b_cnt;
  logic [IC_W-1:0] ic_cnt;
  logic [OC_W-1:0] oc_cnt;
  logic [H_W-1:0]  h_cnt;
  logic [W_W-1:0]  w_cnt;

  logic last_ic, last_pos;
  int   x_idx, w_idx, wr_idx;

  logic [DATA_WIDTH-1:0] x_elem, w_elem, bias_elem, mac_result;

  function automatic logic [DATA_WIDTH-1:0] fill_value(input logic [DATA_WIDTH-1:0] v);
`ifdef DECONV1X1_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign last_ic  = (ic_cnt == IC_LAST);
  assign last_pos = (oc_cnt == OC_LAST) && (w_cnt == W_LAST) &&
                    (h_cnt == H_LAST) && (b_cnt == B_LAST);

  // Moore outputs: reset forces IDLE, which clears both.
  assign busy = (state == ST_FILL) || (state == ST_MAC) || (state == ST_WRITE);
  assign done = (state == ST_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_FILL;
      ST_FILL:  state_next = ST_MAC;
      ST_MAC:   if (last_ic) state_next = ST_WRITE;
      ST_WRITE: state_next = last_pos ? ST_DONE : ST_MAC;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- counters
  // Loop order, innermost first: ic (MAC), then oc, w, h, b (WRITE).
  // Every counter wraps to zero after the final WRITE, so DONE/IDLE
  // always start the next run from the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_cnt  <= '0;
      ic_cnt <= '0;
      oc_cnt <= '0;
      h_cnt  <= '0;
      w_cnt  <= '0;
    end else if (state == ST_MAC) begin
      ic_cnt <= last_ic ? '0 : ic_cnt + 1'b1;
    end else if (state == ST_WRITE) begin
      if (oc_cnt != OC_LAST) begin
        oc_cnt <= oc_cnt + 1'b1;
      end else begin
        oc_cnt <= '0;
        if (w_cnt != W_LAST) begin
          w_cnt <= w_cnt + 1'b1;
        end else begin
          w_cnt <= '0;
          if (h_cnt != H_LAST) begin
            h_cnt <= h_cnt + 1'b1;
          end else begin
            h_cnt <= '0;
            b_cnt <= (b_cnt == B_LAST) ? '0 : b_cnt + 1'b1;
          end
        end
      end
    end
  end

  // ----------------------------------------------------- operand select
  always_comb begin
    x_idx  = tensor_idx(int'(b_cnt), int'(ic_cnt), int'(h_cnt), int'(w_cnt),
                        IN_CHANNELS, IN_HEIGHT, IN_WIDTH);
    // Transposed indexing: the weight is W[ic][oc], not W[oc][ic].
    w_idx  = int'(ic_cnt) * OUT_CHANNELS + int'(oc_cnt);
    wr_idx = tensor_idx(int'(b_cnt), int'(oc_cnt), int'(h_cnt) * STRIDE,
                        int'(w_cnt) * STRIDE, OUT_CHANNELS, OUT_HEIGHT, OUT_WIDTH);
  end

  assign x_elem    = input_tensor_flat[x_idx * DATA_WIDTH +: DATA_WIDTH];
  assign w_elem    = weights_flat[w_idx * DATA_WIDTH +: DATA_WIDTH];
  assign bias_elem = bias_flat[int'(oc_cnt) * DATA_WIDTH +: DATA_WIDTH];

  deconv_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .IN_CHANNELS (IN_CHANNELS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (ic_cnt == '0),
    .en     (state == ST_MAC),
    .x      (x_elem),
    .w      (w_elem),
    .bias   (bias_elem),
    .result (mac_result)
  );

  // ----------------------------------------------------- output register
  // NOTE: this storage is reset because a reset must leave the whole output
  // at zero; large data buffers without that need are normally left unreset.
  // FILL paints every element with its channel bias so gap positions are
  // done; WRITE then overwrites only the stride-grid positions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tensor_flat <= '0;
    end else if (state == ST_FILL) begin
      for (int i = 0; i < OUT_ELEMS; i++) begin
        output_tensor_flat[i * DATA_WIDTH +: DATA_WIDTH] <=
          fill_value(bias_flat[((i / PLANE) % OUT_CHANNELS) * DATA_WIDTH +: DATA_WIDTH]);
      end
    end else if (state == ST_WRITE) begin
      output_tensor_flat[wr_idx * DATA_WIDTH +: DATA_WIDTH] <= mac_result;
    end
  end

endmodule

// File: tb/tb_deconv1x1.sv
// Self-checking bench for deconv1x1: directed tests plus randomized runs,
// compared against an arithmetic reference model of the transposed 1x1
// convolution. Two instances: defaults (a) and IC=OC=2, IH=IW=2, S=2 (b).
// Latency is counted in cycles after the accepting edge, FILL being cycle 1,
// so done is expected in cycle 1 + B*IH*IW*OC*(IC+1) + 1.
module tb_deconv1x1;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance a: defaults (B=1, IC=1, OC=1, 4x4, S=2)
  logic            start_a = 1'b0;
  logic [16*DW-1:0] in_a   = '0;
  logic [DW-1:0]    w_a    = '0;
  logic [DW-1:0]    b_a    = '0;
  logic             busy_a, done_a;
  logic [64*DW-1:0] out_a;

  // Instance b: B=1, IC=2, OC=2, 2x2, S=2
  logic            start_b = 1'b0;
  logic [8*DW-1:0]  in_b   = '0;
  logic [4*DW-1:0]  w_b    = '0;
  logic [2*DW-1:0]  b_b    = '0;
  logic             busy_b, done_b;
  logic [32*DW-1:0] out_b;

  deconv1x1 dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .input_tensor_flat(in_a), .weights_flat(w_a), .bias_flat(b_a),
    .busy(busy_a), .done(done_a), .output_tensor_flat(out_a)
  );

  deconv1x1 #(
    .BATCH_SIZE(1), .IN_CHANNELS(2), .OUT_CHANNELS(2),
    .IN_HEIGHT(2), .IN_WIDTH(2), .STRIDE(2), .DATA_WIDTH(32)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .input_tensor_flat(in_b), .weights_flat(w_b), .bias_flat(b_b),
    .busy(busy_b), .done(done_b), .output_tensor_flat(out_b)
  );

  int total = 0;
  int bad   = 0;

  // Model operands, shared by whichever instance is under test.
  int mx[64];
  int mw[4];
  int mb[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: evaluate the defining equation for one flat output index.
  function automatic logic [31:0] model(input int idx, input int ic_n, input int oc_n,
                                        input int ih, input int iw, input int s);
    int oh, ow, xx, yy, oc, b;
    longint acc;
    logic [31:0] r;
    oh = ih * s;
    ow = iw * s;
    xx = idx % ow;
    yy = (idx / ow) % oh;
    oc = (idx / (ow * oh)) % oc_n;
    b  = idx / (ow * oh * oc_n);
    acc = longint'(mb[oc]);
    if ((yy % s == 0) && (xx % s == 0)) begin
      for (int ic = 0; ic < ic_n; ic++)
        acc += longint'(mx[((b * ic_n + ic) * ih + yy / s) * iw + xx / s]) * longint'(mw[ic * oc_n + oc]);
    end
    r = acc[31:0];
`ifdef DECONV1X1_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  task automatic load_a();
    for (int i = 0; i < 16; i++) in_a[i*DW +: DW] = mx[i];
    w_a = mw[0];
    b_a = mb[0];
  endtask

  task automatic load_b();
    for (int i = 0; i < 8; i++) in_b[i*DW +: DW] = mx[i];
    for (int i = 0; i < 4; i++) w_b[i*DW +: DW] = mw[i];
    for (int i = 0; i < 2; i++) b_b[i*DW +: DW] = mb[i];
  endtask

  task automatic set_start(input bit use_b, input bit v);
    if (use_b) start_b = v;
    else       start_a = v;
  endtask

  // Pulse start, optionally re-pulse it in cycle inject_at, wait (bounded)
  // for done and check latency. Returns at the negedge inside the DONE cycle.
  task automatic run(input bit use_b, input int exp_lat, input int inject_at, input string tag);
    int cycles;
    bit seen;
    @(negedge clk);
    set_start(use_b, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(use_b, 1'b0);
    cycles = 1;
    seen   = 1'b0;
    check({tag, ".busy_fill"}, use_b ? busy_b : busy_a, 1);
    while (!seen && cycles < 300) begin
      if (use_b ? done_b : done_a) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cycles++;
        set_start(use_b, cycles == inject_at);
      end
    end
    set_start(use_b, 1'b0);
    check({tag, ".latency"}, seen ? cycles : -1, exp_lat);
    check({tag, ".busy_done"}, use_b ? busy_b : busy_a, 0);
  endtask

  task automatic check_all(input bit use_b, input string tag);
    int n;
    logic [31:0] obs;
    n = use_b ? 32 : 64;
    for (int i = 0; i < n; i++) begin
      obs = use_b ? out_b[i*DW +: DW] : out_a[i*DW +: DW];
      if (use_b) check($sformatf("%s[%0d]", tag, i), obs, model(i, 2, 2, 2, 2, 2));
      else       check($sformatf("%s[%0d]", tag, i), obs, model(i, 1, 1, 4, 4, 2));
    end
  endtask

  initial begin
    int done_cnt;
    logic [31:0] exp_val;

    // ---------------- reset state
    #1;
    check("reset.busy_a", busy_a, 0);
    check("reset.done_a", done_a, 0);
    check("reset.out_a_zero", {31'b0, |out_a}, 0);
    check("reset.busy_b", busy_b, 0);
    check("reset.out_b_zero", {31'b0, |out_b}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- Test 1: x=0..15, W=2, bias=1
    for (int i = 0; i < 16; i++) mx[i] = i;
    mw[0] = 2;
    mb[0] = 1;
    load_a();
    run(0, 34, -1, "t1");
    check("t1.out0",  out_a[0*DW +: DW], 1);
    check("t1.out2",  out_a[2*DW +: DW], 3);
    check("t1.out16", out_a[16*DW +: DW], 9);
    check("t1.out18", out_a[18*DW +: DW], 11);
    check("t1.out1",  out_a[1*DW +: DW], 1);
    check("t1.out8",  out_a[8*DW +: DW], 1);
    check("t1.out63", out_a[63*DW +: DW], 1);
    check_all(0, "t1");

    // ---------------- Test 4: reset 10 cycles after start
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4.busy", busy_a, 0);
    check("t4.done", done_a, 0);
    check("t4.out_zero", {31'b0, |out_a}, 0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("t4.no_partial_done", done_cnt, 0);
    run(0, 34, -1, "t4.rerun");
    check_all(0, "t4.rerun");

    // ---------------- Test 2: IC=2, OC=2, 2x2
    for (int i = 0; i < 4; i++) mx[i] = 1;
    for (int i = 4; i < 8; i++) mx[i] = 2;
    mw[0] = 1; mw[1] = 2; mw[2] = 3; mw[3] = 4;
    mb[0] = 10; mb[1] = -10;
    load_b();
    run(1, 26, -1, "t2");
    check("t2.oc0_even", out_b[0*DW +: DW], 17);
    check("t2.oc1_even", out_b[(16 + 2)*DW +: DW], 0);
`ifdef DECONV1X1_RELU_EN
    check("t2.oc1_gap", out_b[(16 + 1)*DW +: DW], 0);
`else
    check("t2.oc1_gap", out_b[(16 + 1)*DW +: DW], -10);
`endif
    check("t2.oc0_gap", out_b[5*DW +: DW], 10);
    check_all(1, "t2");

    // ---------------- Test 3: sign handling
    for (int i = 0; i < 16; i++) mx[i] = -3;
    mw[0] = 5;
    mb[0] = 0;
    load_a();
    run(0, 34, -1, "t3");
`ifdef DECONV1X1_RELU_EN
    exp_val = 0;
`else
    exp_val = -15;
`endif
    check("t3.out0", out_a[0*DW +: DW], exp_val);
    check_all(0, "t3");

    // ---------------- Test 6: wraparound
    for (int i = 0; i < 16; i++) mx[i] = 32'h7FFF_FFFF;
    mw[0] = 2;
    mb[0] = 0;
    load_a();
    run(0, 34, -1, "t6");
`ifdef DECONV1X1_RELU_EN
    exp_val = 0;
`else
    exp_val = 32'hFFFF_FFFE;
`endif
    check("t6.out18", out_a[18*DW +: DW], exp_val);
    check_all(0, "t6");

    // ---------------- Test 5: start during MAC is ignored
    for (int i = 0; i < 16; i++) mx[i] = 3 * i - 7;
    mw[0] = -4;
    mb[0] = 6;
    load_a();
    run(0, 34, 5, "t5");
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_a) done_cnt++;
    end
    check("t5.extra_done", done_cnt, 0);
    check("t5.idle_busy", busy_a, 0);
    check_all(0, "t5");

    // ---------------- start coincident with done is ignored
    run(0, 34, -1, "sd");
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("sd.busy_after", busy_a, 0);
    @(negedge clk);
    check("sd.busy_after2", busy_a, 0);

    // ---------------- randomized runs on both instances
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++)
        mx[i] = (it % 2 == 0) ? int'($urandom_range(200)) - 100 : int'($urandom);
      for (int i = 0; i < 4; i++)
        mw[i] = (it % 2 == 0) ? int'($urandom_range(200)) - 100 : int'($urandom);
      for (int i = 0; i < 2; i++)
        mb[i] = (it % 2 == 0) ? int'($urandom_range(200)) - 100 : int'($urandom);
      load_a();
      run(0, 34, -1, $sformatf("rnd_a%0d", it));
      check_all(0, $sformatf("rnd_a%0d", it));
      load_b();
      run(1, 26, -1, $sformatf("rnd_b%0d", it));
      check_all(1, $sformatf("rnd_b%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
